// File: rtl/bsr_pkg.sv
// Shared types for the boundary-scan register: operating modes and
// mode-classification helpers used by both the top and the bench.
package bsr_pkg;

  typedef enum logic [1:0] {
    BYPASS         = 2'd0,
    SAMPLE_PRELOAD = 2'd1,
    EXTEST         = 2'd2,
    CLAMP          = 2'd3
  } bsr_mode_t;

  // Modes in which the WIDTH-bit cell chain sits between TDI and TDO.
  function automatic logic chain_sel(input bsr_mode_t m);
    return (m == SAMPLE_PRELOAD) || (m == EXTEST);
  endfunction

  // Modes in which the pins are driven from the update register.
  function automatic logic pins_from_ur(input bsr_mode_t m);
    return (m == EXTEST) || (m == CLAMP);
  endfunction

endpackage

// File: rtl/bsr_cell.sv
// One boundary cell: capture/shift stage plus update latch.
// Capture beats shift; update always takes the pre-edge shift value.
module bsr_cell (
  input  logic TCK,
  input  logic TRST_N,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic pin,
  input  logic shift_in,
  output logic sr_q,
  output logic ur_q
);

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      sr_q <= 1'b0;
      ur_q <= 1'b0;
    end else begin
      if (capture)    sr_q <= pin;
      else if (shift) sr_q <= shift_in;
      if (update)     ur_q <= sr_q;
    end
  end

endmodule

// File: rtl/boundary_scan_register.sv
// Boundary-scan data register: WIDTH cells, bypass bit, shift counter that
// tracks whether the chain was fully loaded, and a sticky early-update flag.
module boundary_scan_register
  import bsr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             TCK,
  input  logic             TRST_N,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  input  logic             scan_in,
  output logic             scan_out,
  input  logic             CaptureDR,
  input  logic             ShiftDR,
  input  logic             UpdateDR,
  input  bsr_mode_t        mode,
  output logic             chain_loaded,
  output logic             update_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);

  logic [WIDTH-1:0] sr, ur;
  logic [WIDTH:0]   chain_vec;
  logic [CW-1:0]    cnt;
  logic             byp, in_chain;

  assign in_chain  = chain_sel(mode);
  // Cell i shifts from cell i+1; the top cell takes scan_in.
  assign chain_vec = {scan_in, sr};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    bsr_cell u_cell (
      .TCK      (TCK),
      .TRST_N   (TRST_N),
      .capture  (CaptureDR & in_chain),
      .shift    (ShiftDR & in_chain),
      .update   (UpdateDR & in_chain),
      .pin      (data_in[i]),
      .shift_in (chain_vec[i+1]),
      .sr_q     (sr[i]),
      .ur_q     (ur[i])
    );
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      byp        <= 1'b0;
      cnt        <= '0;
      update_err <= 1'b0;
    end else begin
      if (CaptureDR) begin
        cnt        <= '0;
        update_err <= 1'b0;
        if (!in_chain) byp <= 1'b0;
      end else begin
        if (ShiftDR && in_chain && cnt != FULL) cnt <= cnt + 1'b1;
        if (ShiftDR && !in_chain)               byp <= scan_in;
        // Early-update check uses the counter value from before this edge.
        if (UpdateDR && in_chain && cnt != FULL) update_err <= 1'b1;
      end
    end
  end

  assign chain_loaded = (cnt == FULL);
  assign scan_out     = in_chain ? sr[0] : byp;
  assign data_out     = pins_from_ur(mode) ? ur : data_in;

endmodule

// File: tb/tb_boundary_scan_register.sv
// Directed scenarios plus randomized traffic against a queue-based model
// of the boundary-scan register.
module tb_boundary_scan_register;
  import bsr_pkg::*;

  localparam int W = 8;

  logic         TCK = 1'b0;
  logic         TRST_N;
  logic [W-1:0] data_in, data_out;
  logic         scan_in, scan_out, CaptureDR, ShiftDR, UpdateDR;
  bsr_mode_t    mode;
  logic         chain_loaded, update_err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 TCK = ~TCK;

  boundary_scan_register #(.WIDTH(W)) dut (
    .TCK(TCK), .TRST_N(TRST_N), .data_in(data_in), .data_out(data_out),
    .scan_in(scan_in), .scan_out(scan_out), .CaptureDR(CaptureDR),
    .ShiftDR(ShiftDR), .UpdateDR(UpdateDR), .mode(mode),
    .chain_loaded(chain_loaded), .update_err(update_err)
  );

  // Model: q[0] is the TDO end of the chain, q[W-1] the TDI end.
  bit           q[$];
  logic [W-1:0] m_ur;
  bit           m_byp, m_err;
  int           m_cnt;

  function automatic logic [W-1:0] m_sr();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) v[i] = q[i];
    return v;
  endfunction

  function automatic void m_reset();
    q.delete();
    for (int i = 0; i < W; i++) q.push_back(1'b0);
    m_ur = '0; m_byp = 0; m_err = 0; m_cnt = 0;
  endfunction

  function automatic void m_step(bit cap, bit sh, bit upd, logic [1:0] md,
                                 bit si, logic [W-1:0] din);
    bit ch;
    ch = (md == 2'd1) || (md == 2'd2);
    if (upd && ch) begin
      m_ur = m_sr();
      if (m_cnt != W) m_err = 1;
    end
    if (cap) begin
      m_cnt = 0; m_err = 0;
      if (ch) begin
        q.delete();
        for (int i = 0; i < W; i++) q.push_back(din[i]);
      end else m_byp = 0;
    end else if (sh) begin
      if (ch) begin
        void'(q.pop_front());
        q.push_back(si);
        if (m_cnt < W) m_cnt++;
      end else m_byp = si;
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit ch;
    ch = (mode == SAMPLE_PRELOAD) || (mode == EXTEST);
    chk("scan_out",     64'(scan_out),     64'(ch ? q[0] : m_byp));
    chk("data_out",     64'(data_out),
        64'((mode == EXTEST || mode == CLAMP) ? m_ur : data_in));
    chk("chain_loaded", 64'(chain_loaded), 64'(m_cnt == W));
    chk("update_err",   64'(update_err),   64'(m_err));
  endtask

  task automatic cyc(bit cap, bit sh, bit upd, bsr_mode_t md, bit si, logic [W-1:0] din);
    CaptureDR = cap; ShiftDR = sh; UpdateDR = upd;
    mode = md; scan_in = si; data_in = din;
    @(posedge TCK);
    m_step(cap, sh, upd, md, si, din);
    #1;
    check_all();
  endtask

  task automatic idle(bsr_mode_t md, logic [W-1:0] din);
    cyc(0, 0, 0, md, 0, din);
  endtask

  // Asserted and released between edges, so the reset is purely asynchronous.
  task automatic async_reset();
    #1 TRST_N = 1'b0;
    #2;
    m_reset();
    check_all();
    chk("rst_scan_out", 64'(scan_out), 64'(0));
    chk("rst_loaded",   64'(chain_loaded), 64'(0));
    TRST_N = 1'b1;
  endtask

  task automatic preload(bsr_mode_t md, logic [W-1:0] val);
    cyc(1, 0, 0, md, 0, '0);
    for (int i = 0; i < W; i++) cyc(0, 1, 0, md, val[i], '0);
  endtask

  bit exp30[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 1};
  bit pat33[3] = '{1, 0, 1};

  initial begin
    TRST_N = 1'b0; CaptureDR = 0; ShiftDR = 0; UpdateDR = 0;
    scan_in = 0; mode = EXTEST; data_in = 8'hA5;
    m_reset();
    #3;
    check_all();
    chk("rst_extest_dout", 64'(data_out), 64'(8'h00));
    mode = BYPASS; #1;
    chk("rst_bypass_dout", 64'(data_out), 64'(8'hA5));
    TRST_N = 1'b1;

    // Capture 0xAA, then shift eight ones through.
    cyc(1, 0, 0, SAMPLE_PRELOAD, 0, 8'hAA);
    chk("cap_aa_so", 64'(scan_out), 64'(exp30[0]));
    for (int i = 1; i <= W; i++) begin
      cyc(0, 1, 0, SAMPLE_PRELOAD, 1, 8'hAA);
      chk($sformatf("shift_so%0d", i), 64'(scan_out), 64'(exp30[i]));
    end
    chk("loaded_after_8", 64'(chain_loaded), 64'(1));

    // Preload 0x3C and apply it to the pins.
    preload(SAMPLE_PRELOAD, 8'h3C);
    cyc(0, 0, 1, SAMPLE_PRELOAD, 0, 8'h11);
    idle(EXTEST, 8'h11);
    chk("extest_dout_3c", 64'(data_out), 64'(8'h3C));
    chk("extest_err0",    64'(update_err), 64'(0));
    idle(BYPASS, 8'h96);
    chk("bypass_dout", 64'(data_out), 64'(8'h96));

    // Clamp holds pins while bypass bit delays TDI by one shift.
    cyc(1, 0, 0, CLAMP, 0, 8'h77);
    chk("clamp_so0", 64'(scan_out), 64'(0));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, CLAMP, pat33[i], 8'h77);
      chk($sformatf("clamp_so%0d", i + 1), 64'(scan_out), 64'(pat33[i]));
      chk("clamp_dout", 64'(data_out), 64'(8'h3C));
    end
    cyc(0, 1, 1, CLAMP, 0, 8'h77);
    chk("clamp_upd_ignored", 64'(data_out), 64'(8'h3C));
    // Chain still holds 0x3C: bit0=0, bit1=0, bit2=1.
    idle(SAMPLE_PRELOAD, 8'h00);
    chk("sr_kept_b0", 64'(scan_out), 64'(0));
    cyc(0, 1, 0, SAMPLE_PRELOAD, 0, 8'h00);
    cyc(0, 1, 0, SAMPLE_PRELOAD, 0, 8'h00);
    chk("sr_kept_b2", 64'(scan_out), 64'(1));

    // Early update after five shifts.
    cyc(1, 0, 0, EXTEST, 0, 8'hE7);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, EXTEST, 1, 8'h00);
    cyc(0, 0, 1, EXTEST, 0, 8'h00);
    chk("early_err",  64'(update_err), 64'(1));
    chk("early_ur",   64'(data_out),   64'(8'hFF));
    cyc(1, 0, 0, EXTEST, 0, 8'h00);
    chk("err_cleared", 64'(update_err), 64'(0));

    // Capture + shift + update on one edge.
    preload(SAMPLE_PRELOAD, 8'hC3);
    cyc(1, 1, 1, EXTEST, 1, 8'h5A);
    chk("triple_ur",  64'(data_out),     64'(8'hC3));
    chk("triple_cnt", 64'(chain_loaded), 64'(0));
    chk("triple_err", 64'(update_err),   64'(0));
    chk("triple_so",  64'(scan_out),     64'(0));

    // Reset mid-shift.
    cyc(1, 0, 0, EXTEST, 0, 8'hF0);
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, EXTEST, 1, 8'h00);
    cyc(0, 0, 1, EXTEST, 0, 8'h00);
    chk("pre_rst_err", 64'(update_err), 64'(1));
    async_reset();
    chk("rst_mid_dout", 64'(data_out),   64'(8'h00));
    chk("rst_mid_err",  64'(update_err), 64'(0));
    cyc(0, 1, 0, EXTEST, 1, 8'h00);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) async_reset();
      else cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 7) == 0, bsr_mode_t'($urandom_range(0, 3)),
               1'($urandom), W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/boundary_scan_register.md
BOUNDARY_SCAN_REGISTER -- requirements
Module: boundary_scan_register

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, number of boundary cells (1..64).
REQ-002 SHALL have port: TCK  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: TRST_N  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: data_in  input  WIDTH  pin/core-side parallel input.
REQ-005 SHALL have port: data_out  output  WIDTH  parallel output to pins.
REQ-006 SHALL have port: scan_in  input  1  serial input (TDI side).
REQ-007 SHALL have port: scan_out  output  1  serial output (TDO side).
REQ-008 SHALL have ports: CaptureDR, ShiftDR, UpdateDR  input  1 each  TAP-decoded enables, sampled on TCK.
REQ-009 SHALL have port: mode  input  2  bsr_mode_t: BYPASS=0, SAMPLE_PRELOAD=1, EXTEST=2, CLAMP=3.
REQ-010 SHALL have port: chain_loaded  output  1  exactly WIDTH or more shifts since last capture.
REQ-011 SHALL have port: update_err  output  1  sticky, update issued before chain fully loaded.

Function
REQ-012 SHALL hold WIDTH-bit shift register sr, WIDTH-bit update register ur, 1-bit bypass register byp, shift counter cnt (clog2(WIDTH+1) bits), update_err flag.
REQ-013 SHALL, on CaptureDR in SAMPLE_PRELOAD/EXTEST: sr <= data_in; cnt <= 0; update_err <= 0.
REQ-014 SHALL, on CaptureDR in BYPASS/CLAMP: byp <= 0; cnt <= 0; update_err <= 0; sr unchanged.
REQ-015 SHALL, on ShiftDR (no CaptureDR) in SAMPLE_PRELOAD/EXTEST: sr <= {scan_in, sr[WIDTH-1:1]}; cnt increments, saturating at WIDTH.
REQ-016 SHALL, on ShiftDR (no CaptureDR) in BYPASS/CLAMP: byp <= scan_in; sr, cnt unchanged.
REQ-017 SHALL give CaptureDR priority over ShiftDR when both asserted in same cycle.
REQ-018 SHALL, on UpdateDR in SAMPLE_PRELOAD/EXTEST: ur <= sr value present before that edge; if cnt != WIDTH, set update_err.
REQ-019 SHALL, on UpdateDR in BYPASS/CLAMP: leave ur and update_err unchanged.
REQ-020 SHALL, when UpdateDR coincides with CaptureDR or ShiftDR, load ur from pre-edge sr; update_err evaluated against pre-edge cnt, then CaptureDR clear wins.
REQ-021 SHALL drive scan_out combinationally: sr[0] in SAMPLE_PRELOAD/EXTEST, byp in BYPASS/CLAMP; one shift cycle latency scan_in->scan_out in bypass, WIDTH cycles in chain.
REQ-022 SHALL drive data_out combinationally: data_in in BYPASS/SAMPLE_PRELOAD; ur in EXTEST/CLAMP.
REQ-023 SHALL drive chain_loaded = (cnt == WIDTH), combinational from register.
REQ-024 SHALL allow mode change any cycle; registers retain values across mode change.

Reset
REQ-025 SHALL, while TRST_N low, asynchronously force sr, ur, byp, cnt, update_err to 0.
REQ-026 SHALL give reset outputs: scan_out 0, chain_loaded 0, update_err 0, data_out = data_in (BYPASS/SAMPLE_PRELOAD) or 0 (EXTEST/CLAMP).
REQ-027 SHALL, on reset mid-shift, discard partial shift; first edge after deassertion behaves as normal operation.

Structure
REQ-028 SHALL place bsr_mode_t enum and mode constants in shared package bsr_pkg.
REQ-029 SHALL implement per-bit capture/shift/update in sub-module bsr_cell, instantiated WIDTH times by generate; counter, bypass, flags, muxing in top.

Verification
REQ-030 SHALL cover: WIDTH=8, SAMPLE_PRELOAD, data_in=8'hAA, CaptureDR 1 cycle -> sr=8'hAA, scan_out=0; 8 ShiftDR cycles scan_in=1 -> scan_out sequence 0,1,0,1,0,1,0,1 then 1, chain_loaded=1.
REQ-031 SHALL cover: preload 8'h3C via 8 shifts, UpdateDR, mode=EXTEST -> data_out=8'h3C, update_err=0; in BYPASS -> data_out=data_in.
REQ-032 SHALL cover: capture then 5 shifts then UpdateDR in EXTEST -> update_err=1 and ur updated; next CaptureDR -> update_err=0.
REQ-033 SHALL cover: CLAMP after ur=8'h3C, shift scan_in pattern 1,0,1 -> scan_out 0,1,0,1 one cycle delayed, data_out stays 8'h3C, sr unchanged.
REQ-034 SHALL cover: CaptureDR+ShiftDR+UpdateDR same edge -> capture wins on sr, ur gets pre-edge sr, cnt=0.
REQ-035 SHALL cover: TRST_N low after 4 shifts -> all registers 0 immediately (async), chain_loaded=0, EXTEST data_out=8'h00.
